uart_cmd_parser: RTL and testbench

- Consumes the byte stream from the UART receiver (8-bit data plus 1-cycle valid pulse).
- Parses a case-insensitive ASCII register command protocol and drives a simple 8-bit register bus.
- Emits one-byte-at-a-time response characters to the UART transmitter over a valid/ready handshake.
- Sits between uart_rx and the register file / uart_tx in the debug-console path.

---
 rtl/uart_cmd_defs.sv | 35 +++
 rtl/hex_ascii_decode.sv | 25 ++
 rtl/uart_cmd_parser.sv | 155 +++++++++++++++
 tb/tb_uart_cmd_parser.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_defs.sv
// Purpose: shared ASCII constants, FSM state codes and nibble-to-ASCII helper for uart_cmd_parser.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
package uart_cmd_defs;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_W  = 8'h57;
  localparam logic [7:0] ASCII_R  = 8'h52;
  localparam logic [7:0] ASCII_K  = 8'h4B;
  localparam logic [7:0] ASCII_QM = 8'h3F;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_ADDR_HI = 4'd1;
  localparam logic [3:0] S_ADDR_LO = 4'd2;
  localparam logic [3:0] S_DATA_HI = 4'd3;
  localparam logic [3:0] S_DATA_LO = 4'd4;
  localparam logic [3:0] S_EOL     = 4'd5;
  localparam logic [3:0] S_EXEC    = 4'd6;
  localparam logic [3:0] S_RD_WAIT = 4'd7;
  localparam logic [3:0] S_RESP_HI = 4'd8;
  localparam logic [3:0] S_RESP_LO = 4'd9;
  localparam logic [3:0] S_DRAIN   = 4'd10;
  localparam logic [3:0] S_ERR     = 4'd11;

  // Uppercase hex character for a nibble.
  function automatic logic [7:0] nib2ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  function automatic logic is_term(input logic [7:0] b);
    return (b == ASCII_CR) || (b == ASCII_LF);
  endfunction

endpackage

// File: rtl/hex_ascii_decode.sv
// Purpose: classify an ASCII byte as a hex digit (0-9, A-F, a-f) and return its value.
// Latency: combinational.
// Backpressure: n/a.
// Ports: i_byte (ASCII in), o_nibble (digit value, 0 when not hex), o_is_hex (byte is a hex digit).
module hex_ascii_decode (
  input  logic [7:0] i_byte,
  output logic [3:0] o_nibble,
  output logic       o_is_hex
);

  always_comb begin
    o_nibble = 4'h0;
    o_is_hex = 1'b0;
    if (i_byte >= 8'h30 && i_byte <= 8'h39) begin
      o_nibble = i_byte[3:0];
      o_is_hex = 1'b1;
    end else if ((i_byte >= 8'h41 && i_byte <= 8'h46) ||
                 (i_byte >= 8'h61 && i_byte <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so +9 lands on 10.
      o_nibble = i_byte[3:0] + 4'd9;
      o_is_hex = 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Purpose: parse case-insensitive "Waadd<EOL>" / "Raa<EOL>" console commands into register bus strobes and ASCII replies.
// Latency: strobe 1 cycle after the terminator; read data on o_tx_data 3 cycles after the terminator.
// Backpressure: reply held on o_tx_valid until i_tx_ready; rx bytes arriving while busy are dropped with o_overrun.
// Ports: i_clk/i_reset (async active-high); i_rx_data/i_rx_valid byte stream in;
//        o_wr_en/o_rd_en/o_addr/o_wdata/i_rdata register bus; o_tx_data/o_tx_valid/i_tx_ready reply out;
//        o_overrun dropped-byte pulse.
// Optional: define CMD_TIMEOUT_EN to abort a partial command after TIMEOUT_MS ms of rx idle (replies '?').
module uart_cmd_parser
  import uart_cmd_defs::*;
#(
  parameter int CLK_FREQ   = 25_000_000,
  parameter int TIMEOUT_MS = 100
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  output logic       o_wr_en,
  output logic       o_rd_en,
  output logic [7:0] o_addr,
  output logic [7:0] o_wdata,
  input  logic [7:0] i_rdata,
  output logic [7:0] o_tx_data,
  output logic       o_tx_valid,
  input  logic       i_tx_ready,
  output logic       o_overrun
);

  logic [3:0] r_state;
  logic       r_op_wr;
  logic [7:0] r_addr;
  logic [7:0] r_wdata;
  logic [7:0] r_rdata;
  logic       r_overrun;

  logic [3:0] w_nibble;
  logic       w_is_hex;
  logic       w_is_term;
  logic [7:0] w_upper;
  logic       w_busy;
  logic       w_tmo_expired;
  logic [7:0] w_tx_data;

  hex_ascii_decode u_hex (
    .i_byte   (i_rx_data),
    .o_nibble (w_nibble),
    .o_is_hex (w_is_hex)
  );

  assign w_is_term = is_term(i_rx_data);
  // Clearing bit 5 folds lowercase letters onto uppercase.
  assign w_upper   = i_rx_data & 8'hDF;
  assign w_busy    = (r_state == S_EXEC) || (r_state == S_RD_WAIT) || (r_state == S_RESP_HI) ||
                     (r_state == S_RESP_LO) || (r_state == S_ERR);

`ifdef CMD_TIMEOUT_EN
  localparam int TMO_CYCLES = CLK_FREQ / 1000 * TIMEOUT_MS;

  logic [31:0] r_tmo_cnt;
  logic        w_tmo_run;

  assign w_tmo_run = ((r_state >= S_ADDR_HI) && (r_state <= S_EOL)) || (r_state == S_DRAIN);
  assign w_tmo_expired = w_tmo_run && !i_rx_valid && (r_tmo_cnt == 32'(TMO_CYCLES - 1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_tmo_cnt <= '0;
    end else if (i_rx_valid || !w_tmo_run) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 32'd1;
    end
  end
`else
  assign w_tmo_expired = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_op_wr   <= 1'b0;
      r_addr    <= 8'h00;
      r_wdata   <= 8'h00;
      r_rdata   <= 8'h00;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= i_rx_valid && w_busy;
      if (w_tmo_expired) begin
        r_state <= S_ERR;
      end else begin
        case (r_state)
          S_IDLE: if (i_rx_valid) begin
            if (w_upper == ASCII_W) begin
              r_op_wr <= 1'b1;
              r_state <= S_ADDR_HI;
            end else if (w_upper == ASCII_R) begin
              r_op_wr <= 1'b0;
              r_state <= S_ADDR_HI;
            end else if (!w_is_term) begin
              r_state <= S_DRAIN;
            end
          end
          S_ADDR_HI, S_ADDR_LO: if (i_rx_valid) begin
            if (w_is_hex) begin
              r_addr  <= {r_addr[3:0], w_nibble};
              r_state <= (r_state == S_ADDR_HI) ? S_ADDR_LO :
                         (r_op_wr ? S_DATA_HI : S_EOL);
            end else begin
              r_state <= S_DRAIN;
            end
          end
          S_DATA_HI, S_DATA_LO: if (i_rx_valid) begin
            if (w_is_hex) begin
              r_wdata <= {r_wdata[3:0], w_nibble};
              r_state <= (r_state == S_DATA_HI) ? S_DATA_LO : S_EOL;
            end else begin
              r_state <= S_DRAIN;
            end
          end
          S_EOL:     if (i_rx_valid) r_state <= w_is_term ? S_EXEC : S_DRAIN;
          S_DRAIN:   if (i_rx_valid && w_is_term) r_state <= S_ERR;
          S_EXEC:    r_state <= r_op_wr ? S_RESP_LO : S_RD_WAIT;
          S_RD_WAIT: begin
            r_rdata <= i_rdata;
            r_state <= S_RESP_HI;
          end
          S_RESP_HI: if (i_tx_ready) r_state <= S_RESP_LO;
          S_RESP_LO: if (i_tx_ready) r_state <= S_IDLE;
          S_ERR:     if (i_tx_ready) r_state <= S_IDLE;
          default:   r_state <= S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    w_tx_data = 8'h00;
    case (r_state)
      S_RESP_HI: w_tx_data = nib2ascii(r_rdata[7:4]);
      S_RESP_LO: w_tx_data = r_op_wr ? ASCII_K : nib2ascii(r_rdata[3:0]);
      S_ERR:     w_tx_data = ASCII_QM;
      default:   w_tx_data = 8'h00;
    endcase
  end

  // Strobes and tx valid decode straight from state so reset clears them asynchronously.
  assign o_wr_en    = (r_state == S_EXEC) && r_op_wr;
  assign o_rd_en    = (r_state == S_EXEC) && !r_op_wr;
  assign o_addr     = r_addr;
  assign o_wdata    = r_wdata;
  assign o_tx_valid = (r_state == S_RESP_HI) || (r_state == S_RESP_LO) || (r_state == S_ERR);
  assign o_tx_data  = w_tx_data;
  assign o_overrun  = r_overrun;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Purpose: directed self-checking bench for uart_cmd_parser with tx/strobe scoreboards.
// Latency: n/a.
// Backpressure: i_tx_ready toggled by the directed steps.
module tb_uart_cmd_parser;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic [7:0] i_rx_data = 8'h00;
  logic       i_rx_valid = 1'b0;
  logic       o_wr_en, o_rd_en, o_tx_valid, o_overrun;
  logic [7:0] o_addr, o_wdata, o_tx_data;
  logic [7:0] i_rdata = 8'hFF;
  logic       i_tx_ready = 1'b1;

  always #5 i_clk = ~i_clk;

  uart_cmd_parser #(.CLK_FREQ(1_000_000), .TIMEOUT_MS(1)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_rx_data  (i_rx_data),
    .i_rx_valid (i_rx_valid),
    .o_wr_en    (o_wr_en),
    .o_rd_en    (o_rd_en),
    .o_addr     (o_addr),
    .o_wdata    (o_wdata),
    .i_rdata    (i_rdata),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .i_tx_ready (i_tx_ready),
    .o_overrun  (o_overrun)
  );

  int n_cmp = 0;
  int n_mis = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int ovr_cnt = 0;
  logic [7:0]  tx_q[$];
  logic [15:0] wr_q[$];
  logic [7:0]  rd_q[$];
  logic [7:0]  rd_val = 8'h00;
  logic        rd_d = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: read data is presented only on the cycle after o_rd_en; everything else sees 0xFF.
  always @(negedge i_clk) begin
    i_rdata = rd_d ? rd_val : 8'hFF;
    rd_d = o_rd_en;
    if (o_overrun) ovr_cnt++;
    if (o_tx_valid && i_tx_ready) begin
      if (tx_q.size() == 0) begin
        n_cmp++; n_mis++;
        $error("FAIL tx_extra: observed %0h expected none", o_tx_data);
      end else chk("tx_byte", {24'h0, o_tx_data}, {24'h0, tx_q.pop_front()});
    end
    if (o_wr_en) begin
      wr_cnt++;
      if (wr_q.size() == 0) begin
        n_cmp++; n_mis++;
        $error("FAIL wr_extra: observed %0h/%0h expected none", o_addr, o_wdata);
      end else chk("wr_addr_data", {16'h0, o_addr, o_wdata}, {16'h0, wr_q.pop_front()});
    end
    if (o_rd_en) begin
      rd_cnt++;
      if (rd_q.size() == 0) begin
        n_cmp++; n_mis++;
        $error("FAIL rd_extra: observed %0h expected none", o_addr);
      end else chk("rd_addr", {24'h0, o_addr}, {24'h0, rd_q.pop_front()});
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge i_clk); #1;
    i_rx_data = b;
    i_rx_valid = 1'b1;
    @(posedge i_clk); #1;
    i_rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic wait_drained(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (tx_q.size() == 0 && !o_tx_valid) break;
      @(posedge i_clk); #1;
    end
    chk(tag, tx_q.size(), 0);
    chk({tag, "_idle"}, {31'h0, o_tx_valid}, 0);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (o_tx_valid) break;
      @(posedge i_clk); #1;
    end
    chk(tag, {31'h0, o_tx_valid}, 1);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_wr"}, {31'h0, o_wr_en}, 0);
    chk({tag, "_rd"}, {31'h0, o_rd_en}, 0);
    chk({tag, "_txv"}, {31'h0, o_tx_valid}, 0);
    chk({tag, "_txd"}, {24'h0, o_tx_data}, 0);
    chk({tag, "_ovr"}, {31'h0, o_overrun}, 0);
    chk({tag, "_addr"}, {24'h0, o_addr}, 0);
    chk({tag, "_wdata"}, {24'h0, o_wdata}, 0);
  endtask

  initial begin
    int v;
    // Reset state
    #1 chk_outputs_zero("reset");
    repeat (2) @(posedge i_clk);
    #1 i_reset = 1'b0;

    // Write: one strobe, 'K' reply
    tx_q.push_back(8'h4B);
    wr_q.push_back(16'h3CA5);
    send_str("W3Ca5");
    send_byte(8'h0D);
    chk("wr_strobe_lat", {31'h0, o_wr_en}, 1);
    wait_drained("wr_reply", 20);
    chk("addr_held", {24'h0, o_addr}, 32'h3C);

    // Read with 5 cycles of backpressure
    i_tx_ready = 1'b0;
    rd_val = 8'h7E;
    rd_q.push_back(8'h10);
    tx_q.push_back(8'h37);
    tx_q.push_back(8'h45);
    send_str("r10");
    send_byte(8'h0A);
    chk("rd_strobe_lat", {31'h0, o_rd_en}, 1);
    @(posedge i_clk); #1;
    chk("rd_wait_no_valid", {31'h0, o_tx_valid}, 0);
    @(posedge i_clk); #1;
    chk("rd_data_lat", {31'h0, o_tx_valid}, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      chk("hold_valid", {31'h0, o_tx_valid}, 1);
      chk("hold_data", {24'h0, o_tx_data}, 32'h37);
    end
    @(posedge i_clk); #1 i_tx_ready = 1'b1;
    wait_drained("rd_reply", 20);

    // Error: bad hex, single '?'
    tx_q.push_back(8'h3F);
    send_str("WZZ");
    send_byte(8'h0D);
    wait_drained("err_reply", 20);

    // Overrun while reply stalled
    i_tx_ready = 1'b0;
    rd_val = 8'hC3;
    rd_q.push_back(8'h55);
    tx_q.push_back(8'h43);
    tx_q.push_back(8'h33);
    send_str("R55");
    send_byte(8'h0D);
    wait_valid("ovr_resp_hi", 10);
    send_byte("X");
    @(posedge i_clk); #1;
    chk("ovr_pulse", ovr_cnt, 1);
    chk("ovr_resp_kept", {24'h0, o_tx_data}, 32'h43);
    i_tx_ready = 1'b1;
    wait_drained("ovr_reply", 20);
    tx_q.push_back(8'h4B);
    wr_q.push_back(16'h7F00);
    send_str("w7f00");
    send_byte(8'h0A);
    wait_drained("post_ovr_wr", 20);

    // Reset while a reply is stalled
    i_tx_ready = 1'b0;
    rd_val = 8'h9A;
    rd_q.push_back(8'h40);
    send_str("R40");
    send_byte(8'h0D);
    wait_valid("rst_resp", 10);
    chk("rst_resp_data", {24'h0, o_tx_data}, 32'h39);
    #3 i_reset = 1'b1;
    #1 chk_outputs_zero("rst_mid_resp");
    @(posedge i_clk); #1 i_reset = 1'b0;
    i_tx_ready = 1'b1;

    // Reset mid "R4", then a full read
    send_str("R4");
    #2 i_reset = 1'b1;
    #1 chk_outputs_zero("rst_mid_cmd");
    @(posedge i_clk); #1 i_reset = 1'b0;
    rd_q.push_back(8'h40);
    tx_q.push_back(8'h39);
    tx_q.push_back(8'h41);
    send_str("R40");
    send_byte(8'h0D);
    wait_drained("post_rst_rd", 20);

    // Partial command idle gap
`ifdef CMD_TIMEOUT_EN
    tx_q.push_back(8'h3F);
`endif
    send_str("W1");
    v = 0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge i_clk);
      if (o_tx_valid) v++;
    end
`ifdef CMD_TIMEOUT_EN
    chk("timeout_reply", tx_q.size(), 0);
    chk("timeout_one_char", v, 1);
`else
    chk("no_timeout", v, 0);
    tx_q.push_back(8'h3F);
    send_byte(8'h0D);
    send_byte(8'h0D);
    wait_drained("no_timeout_cleanup", 20);
`endif

    // Totals
    repeat (3) @(posedge i_clk);
    #1;
    chk("wr_total", wr_cnt, 2);
    chk("rd_total", rd_cnt, 4);
    chk("ovr_total", ovr_cnt, 1);
    chk("tx_q_empty", tx_q.size(), 0);
    chk("wr_q_empty", wr_q.size(), 0);
    chk("rd_q_empty", rd_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
